servo_cmd_ramp: RTL and testbench

Upstream command stage for the servo PWM generator. It debounces the raw "move" pushbutton and captures the switch target (direction + 7-bit position) on each accepted press. It then slews the commanded position toward that target in bounded steps at a fixed update rate. Each update is presented on `cmd[7:0]` with a one-cycle `move` strobe, which drives the PWM stage's `switches` and `move` inputs directly.

---
 rtl/servo_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/servo_cmd_ramp.sv | 98 +++++++++
 tb/tb_servo_cmd_ramp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and sign-magnitude helpers for the servo command path.
package servo_pkg;

  localparam int unsigned CMD_W     = 8;
  localparam logic        MOV_LEFT  = 1'b0;
  localparam logic        MOV_RIGHT = 1'b1;

  typedef enum logic {
    IDLE,
    RAMP
  } ramp_state_e;

  // Left 0 and right 0 both land on zero.
  function automatic logic signed [CMD_W-1:0] sm_to_signed(input logic [CMD_W-1:0] sm);
    logic signed [CMD_W-1:0] mag;
    mag = {1'b0, sm[CMD_W-2:0]};
    return (sm[CMD_W-1] == MOV_RIGHT) ? mag : -mag;
  endfunction

  function automatic logic [CMD_W-1:0] signed_to_sm(input logic signed [CMD_W-1:0] v);
    if (v > 0) begin
      return {MOV_RIGHT, v[CMD_W-2:0]};
    end else if (v < 0) begin
      return {MOV_LEFT, (CMD_W-1)'(-v)};
    end
    return '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q, prev_q, level_q, rise_q;
  logic          level_d, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter saturates at CNT_LAST so a long-held level stays accepted.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/servo_cmd_ramp.sv
// Captures a debounced target and slews the servo command toward it in bounded steps,
// emitting one registered cmd/move update per divider tick.
module servo_cmd_ramp
  import servo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned STEP_CYCLES     = 1_000_000,
  parameter int unsigned STEP            = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] switches,
  input  logic             move_btn,
  output logic [CMD_W-1:0] cmd,
  output logic             move,
  output logic             busy,
  output logic             at_target
);

  localparam int unsigned DW = $clog2(STEP_CYCLES + 1);
  localparam logic [DW-1:0]    DIV_LAST = DW'(STEP_CYCLES - 1);
  localparam logic [CMD_W-1:0] STEP_MAG = CMD_W'(STEP);

  logic btn_level, btn_rise;
  logic accept, tick, step_en;

  logic [DW-1:0]           div_q, div_d;
  logic signed [CMD_W-1:0] cur_q, cur_d, tgt_q, tgt_d;
  logic signed [CMD_W:0]   diff;
  logic [CMD_W-1:0]        mag, step_mag;
  logic [CMD_W-1:0]        cmd_q, cmd_d;
  logic                    move_q, move_d, busy_q, busy_d, at_target_q, at_target_d;
  ramp_state_e             state_q, state_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(move_btn),
    .level  (btn_level),
    .rise   (btn_rise)
  );

  // The step is computed against the post-accept target, so a retarget that
  // coincides with a tick is applied to that very tick.
  always_comb begin
    accept   = btn_rise & btn_level;
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + 1'b1;
    tgt_d    = accept ? sm_to_signed(switches) : tgt_q;
    diff     = {tgt_d[CMD_W-1], tgt_d} - {cur_q[CMD_W-1], cur_q};
    mag      = diff[CMD_W] ? CMD_W'(-diff) : diff[CMD_W-1:0];
    step_mag = (mag > STEP_MAG) ? STEP_MAG : mag;
    step_en  = tick && (diff != 0) && ((state_q == RAMP) || accept);

    cur_d  = cur_q;
    cmd_d  = cmd_q;
    move_d = 1'b0;
    if (step_en) begin
      cur_d  = diff[CMD_W] ? cur_q - step_mag : cur_q + step_mag;
      cmd_d  = signed_to_sm(cur_d);
      move_d = 1'b1;
    end

    state_d     = (cur_d != tgt_d) ? RAMP : IDLE;
    busy_d      = (cur_d != tgt_d);
    at_target_d = (cur_d == tgt_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      cur_q       <= '0;
      tgt_q       <= '0;
      cmd_q       <= '0;
      move_q      <= 1'b0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b1;
      state_q     <= IDLE;
    end else begin
      div_q       <= div_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      cmd_q       <= cmd_d;
      move_q      <= move_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
      state_q     <= state_d;
    end
  end

  assign cmd       = cmd_q;
  assign move      = move_q;
  assign busy      = busy_q;
  assign at_target = at_target_q;

endmodule

// File: tb/tb_servo_cmd_ramp.sv
// Randomized and directed stimulus against a behavioural model of the servo command ramp.
module tb_servo_cmd_ramp;

  localparam int D   = 4;
  localparam int S   = 10;
  localparam int STP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       move_btn = 1'b0;
  logic [7:0] switches = 8'h00;
  logic [7:0] cmd;
  logic       move, busy, at_target;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit         rq[$];
  bit         m_lev, m_rise, prev_move;
  int         m_edges, m_cur, m_tgt;
  logic [7:0] e_cmd;
  bit         e_move, e_busy, e_at;

  servo_cmd_ramp #(
    .DEBOUNCE_CYCLES(D),
    .STEP_CYCLES    (S),
    .STEP           (STP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .move_btn (move_btn),
    .cmd      (cmd),
    .move     (move),
    .busy     (busy),
    .at_target(at_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sm2int(input logic [7:0] sm);
    int mag;
    mag = int'(sm & 8'h7f);
    return sm[7] ? mag : -mag;
  endfunction

  function automatic logic [7:0] int2sm(input int v);
    if (v > 0) return 8'(128 + v);
    if (v < 0) return 8'(-v);
    return 8'h00;
  endfunction

  task automatic model_reset();
    rq.delete();
    for (int i = 0; i < D + 3; i++) rq.push_back(1'b0);
    m_lev   = 0;
    m_rise  = 0;
    m_edges = 0;
    m_cur   = 0;
    m_tgt   = 0;
    e_cmd   = 8'h00;
    e_move  = 0;
    e_busy  = 0;
    e_at    = 1;
  endtask

  // One clock edge: accept seen last edge takes switches now; ticks every S edges;
  // the button level is accepted once its 2-cycle-delayed copy has been constant for D+1 samples.
  task automatic model_edge(input bit raw, input logic [7:0] sw);
    bit accept, tick, stable;
    int tgt_eff, d;
    accept  = m_rise;
    tick    = (m_edges % S) == S - 1;
    m_edges++;
    tgt_eff = accept ? sm2int(sw) : m_tgt;
    e_move  = 0;
    if (tick && tgt_eff != m_cur) begin
      d = tgt_eff - m_cur;
      if (d > STP) d = STP;
      if (d < -STP) d = -STP;
      m_cur += d;
      e_cmd  = int2sm(m_cur);
      e_move = 1;
    end
    m_tgt  = tgt_eff;
    e_busy = (m_cur != m_tgt);
    e_at   = !e_busy;
    rq.push_back(raw);
    void'(rq.pop_front());
    stable = 1;
    for (int i = 1; i <= D; i++) if (rq[i] != rq[0]) stable = 0;
    m_rise = 0;
    if (stable) begin
      m_rise = rq[D] && !m_lev;
      m_lev  = rq[D];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else model_edge(move_btn, switches);
    chk("cmd", cmd, e_cmd);
    chk("move", move, e_move);
    chk("busy", busy, e_busy);
    chk("at_target", at_target, e_at);
    chk("move_spacing", move & prev_move, 1'b0);
    prev_move = move;
  endtask

  task automatic press(input logic [7:0] sw, input int hold, input int gap, input bit rnd_sw);
    switches = sw;
    move_btn = 1'b1;
    repeat (hold) begin
      if (rnd_sw) switches = 8'($urandom);
      cyc();
    end
    move_btn = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
    end
    chk("settle_busy", busy, 1'b0);
  endtask

  task automatic wait_strobe(input int budget);
    int n;
    n = 0;
    while (!move && n < budget) begin
      cyc();
      n++;
    end
    chk("strobe_seen", move, 1'b1);
  endtask

  // Reset is pulled mid-cycle so the outputs must clear without a clock edge.
  task automatic async_reset_check();
    #2 rst = 1'b0;
    #1;
    chk("arst_cmd", cmd, 8'h00);
    chk("arst_move", move, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_at_target", at_target, 1'b1);
    model_reset();
    prev_move = 0;
    repeat (3) cyc();
    rst = 1'b1;
  endtask

  initial begin
    prev_move = 0;
    model_reset();
    repeat (3) cyc();
    rst = 1'b1;
    repeat (12) cyc();

    // Bouncing button, then a clean hold: exactly one accept of right 5.
    switches = 8'h85;
    for (int i = 0; i < 10; i++) begin
      move_btn = ~move_btn;
      repeat (2) cyc();
    end
    press(8'h85, 10, 12, 0);
    wait_idle(60);

    press(8'h94, 10, 2, 0);   // 0 -> right 20
    wait_idle(80);
    press(8'h0A, 10, 2, 0);   // right 20 -> left 10 across zero
    wait_idle(100);
    press(8'h00, 10, 2, 0);
    wait_idle(60);

    // Retarget mid-ramp, then land on neutral and step right 2.
    press(8'h94, 10, 0, 0);
    wait_strobe(40);
    press(8'h02, 10, 2, 0);
    wait_idle(80);
    press(8'h82, 10, 2, 0);
    wait_idle(60);
    press(8'h00, 10, 2, 0);
    wait_idle(60);

    // Right 0 equals current zero: no strobe, busy stays low.
    press(8'h80, 10, 20, 0);

    // Reset mid-ramp toward 7F; ramp must not resume.
    press(8'h7F, 10, 15, 0);
    async_reset_check();
    repeat (30) cyc();

    for (int i = 0; i < 25; i++) begin
      press(8'($urandom), $urandom_range(2, 12), $urandom_range(3, 50), 1'($urandom_range(0, 1)));
      if (i == 12) async_reset_check();
    end
    wait_idle(400);
    repeat (12) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
